arc4_encrypt: RTL and testbench



---
 rtl/arc4_pkg.sv | 22 ++
 rtl/arc4_ksa.sv | 94 +++++++++
 rtl/arc4_encrypt.sv | 146 ++++++++++++++
 tb/tb_arc4_encrypt.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arc4_pkg.sv
// arc4_pkg: shared states, constants and key-byte helper for the ARC4 encryptor
// Contents: KEYLEN / SBOX_SIZE constants, top-level and INIT+KSA state enums,
//   keybyte() which picks key byte n with byte 0 being the MSB byte.
package arc4_pkg;
    localparam int KEYLEN    = 3;
    localparam int SBOX_SIZE = 256;
    localparam int KIW       = $clog2(KEYLEN);

    typedef enum logic [3:0] {
        IDLE, LEN_RD, LEN_WR, INIT_KSA,
        PRGA_RI, PRGA_LI, PRGA_LJ, PRGA_WJ, PRGA_RP, PRGA_WC,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        KSA_IDLE, INIT, KSA_RI, KSA_LI, KSA_LJ, KSA_WJ
    } ksa_state_e;

    function automatic logic [7:0] keybyte(input logic [8*KEYLEN-1:0] key, input logic [KIW-1:0] n);
        return 8'(key >> (8 * (KEYLEN - 1 - int'(n))));
    endfunction
endpackage

// File: rtl/arc4_ksa.sv
// arc4_ksa: S-box identity fill followed by the ARC4 key schedule
// Ports: clk_i/rst_ni clock and sync active-low reset; start_i one-cycle start;
//   key_i latched key; done_o high in the final KSA write cycle;
//   s_* single-port S-box RAM (1-cycle read latency), all zero while idle.
module arc4_ksa
    import arc4_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [8*KEYLEN-1:0] key_i,
    output logic                done_o,
    output logic [7:0]          s_addr_o,
    output logic [7:0]          s_wrdata_o,
    output logic                s_wren_o,
    input  logic [7:0]          s_rddata_i
);
    ksa_state_e     state_q, state_d;
    logic [7:0]     i_q, i_d, j_q, j_d, si_q, si_d;
    logic [KIW-1:0] kidx_q, kidx_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= KSA_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            kidx_q  <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            kidx_q  <= kidx_d;
        end
    end

    // Per KSA step: read S[i]; latch it and issue read of S[j] from the fresh j;
    // write S[i]=S[j] straight from the read data; write S[j]=old S[i].
    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        si_d       = si_q;
        kidx_d     = kidx_q;
        done_o     = 1'b0;
        s_addr_o   = '0;
        s_wrdata_o = '0;
        s_wren_o   = 1'b0;
        case (state_q)
            KSA_IDLE: begin
                if (start_i) begin
                    state_d = INIT;
                    i_d     = '0;
                    j_d     = '0;
                    kidx_d  = '0;
                end
            end
            INIT: begin
                s_addr_o   = i_q;
                s_wrdata_o = i_q;
                s_wren_o   = 1'b1;
                i_d        = i_q + 8'd1;
                state_d    = (i_q == 8'(SBOX_SIZE - 1)) ? KSA_RI : INIT;
            end
            KSA_RI: begin
                s_addr_o = i_q;
                state_d  = KSA_LI;
            end
            KSA_LI: begin
                si_d     = s_rddata_i;
                j_d      = j_q + s_rddata_i + keybyte(key_i, kidx_q);
                s_addr_o = j_d;
                kidx_d   = (kidx_q == KIW'(KEYLEN - 1)) ? '0 : kidx_q + 1'b1;
                state_d  = KSA_LJ;
            end
            KSA_LJ: begin
                s_addr_o   = i_q;
                s_wrdata_o = s_rddata_i;
                s_wren_o   = 1'b1;
                state_d    = KSA_WJ;
            end
            KSA_WJ: begin
                s_addr_o   = j_q;
                s_wrdata_o = si_q;
                s_wren_o   = 1'b1;
                i_d        = i_q + 8'd1;
                done_o     = (i_q == 8'(SBOX_SIZE - 1));
                state_d    = done_o ? KSA_IDLE : KSA_RI;
            end
            default: state_d = KSA_IDLE;
        endcase
    end
endmodule

// File: rtl/arc4_encrypt.sv
// arc4_encrypt: ARC4 encryptor, length-prefixed pt memory to length-prefixed ct memory
// Ports: clk_i/rst_ni clock and sync active-low reset; en_i/rdy_o start handshake;
//   key_i 24-bit key latched on start; pt_* plaintext read port (1-cycle latency);
//   ct_* ciphertext write port; s_* single-port S-box RAM, owned by arc4_ksa during INIT/KSA.
// Latency: rdy_o is low for exactly 1282 + 6*len cycles after the accepting edge.
module arc4_encrypt
    import arc4_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    output logic                rdy_o,
    input  logic [8*KEYLEN-1:0] key_i,
    output logic [7:0]          pt_addr_o,
    input  logic [7:0]          pt_rddata_i,
    output logic [7:0]          ct_addr_o,
    output logic [7:0]          ct_wrdata_o,
    output logic                ct_wren_o,
    output logic [7:0]          s_addr_o,
    output logic [7:0]          s_wrdata_o,
    output logic                s_wren_o,
    input  logic [7:0]          s_rddata_i
);
    state_e              state_q, state_d;
    logic [8*KEYLEN-1:0] key_q, key_d;
    logic [7:0]          len_q, len_d, i_q, i_d, j_q, j_d, k_q, k_d, si_q, si_d, sj_q, sj_d;
    logic                ksa_start, ksa_done, ksa_wren, p_wren;
    logic [7:0]          ksa_addr, ksa_wrdata, p_addr, p_wrdata;

    arc4_ksa u_ksa (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (ksa_start),
        .key_i      (key_q),
        .done_o     (ksa_done),
        .s_addr_o   (ksa_addr),
        .s_wrdata_o (ksa_wrdata),
        .s_wren_o   (ksa_wren),
        .s_rddata_i (s_rddata_i)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            key_q   <= '0;
            len_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            len_q   <= len_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        len_d       = len_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        si_d        = si_q;
        sj_d        = sj_q;
        rdy_o       = 1'b0;
        pt_addr_o   = '0;
        ct_addr_o   = '0;
        ct_wrdata_o = '0;
        ct_wren_o   = 1'b0;
        p_addr      = '0;
        p_wrdata    = '0;
        p_wren      = 1'b0;
        ksa_start   = 1'b0;
        case (state_q)
            // DONE already reports ready so a back-to-back start lands right after the last ct write
            IDLE, DONE: begin
                rdy_o   = 1'b1;
                key_d   = en_i ? key_i : key_q;
                state_d = en_i ? LEN_RD : IDLE;
            end
            LEN_RD: state_d = LEN_WR;
            LEN_WR: begin
                len_d       = pt_rddata_i;
                ct_wrdata_o = pt_rddata_i;
                ct_wren_o   = 1'b1;
                ksa_start   = 1'b1;
                i_d         = '0;
                j_d         = '0;
                k_d         = 8'd1;
                state_d     = INIT_KSA;
            end
            INIT_KSA: if (ksa_done) state_d = (len_q == 8'd0) ? DONE : PRGA_RI;
            PRGA_RI: begin
                i_d     = i_q + 8'd1;
                p_addr  = i_d;
                state_d = PRGA_LI;
            end
            PRGA_LI: begin
                si_d    = s_rddata_i;
                j_d     = j_q + s_rddata_i;
                p_addr  = j_d;
                state_d = PRGA_LJ;
            end
            PRGA_LJ: begin
                sj_d     = s_rddata_i;
                p_addr   = i_q;
                p_wrdata = s_rddata_i;
                p_wren   = 1'b1;
                state_d  = PRGA_WJ;
            end
            PRGA_WJ: begin
                p_addr   = j_q;
                p_wrdata = si_q;
                p_wren   = 1'b1;
                state_d  = PRGA_RP;
            end
            // Pad index is order-independent of the swap, and the swap has committed by now
            PRGA_RP: begin
                p_addr    = si_q + sj_q;
                pt_addr_o = k_q;
                state_d   = PRGA_WC;
            end
            // k compared before increment so len=255 stops without needing k to wrap
            PRGA_WC: begin
                ct_addr_o   = k_q;
                ct_wrdata_o = pt_rddata_i ^ s_rddata_i;
                ct_wren_o   = 1'b1;
                k_d         = k_q + 8'd1;
                state_d     = (k_q == len_q) ? DONE : PRGA_RI;
            end
            default: state_d = IDLE;
        endcase
    end

    assign s_addr_o   = (state_q == INIT_KSA) ? ksa_addr   : p_addr;
    assign s_wrdata_o = (state_q == INIT_KSA) ? ksa_wrdata : p_wrdata;
    assign s_wren_o   = (state_q == INIT_KSA) ? ksa_wren   : p_wren;
endmodule

// File: tb/tb_arc4_encrypt.sv
// tb_arc4_encrypt: randomized self-checking bench for arc4_encrypt against a software ARC4 model
module tb_arc4_encrypt;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [23:0] key = '0;
    logic        rdy, ct_wren, s_wren;
    logic [7:0]  pt_addr, pt_rddata, ct_addr, ct_wrdata, s_addr, s_wrdata, s_rddata;
    logic [7:0]  pt_mem [256];
    logic [7:0]  ct_mem [256];
    logic [7:0]  s_mem  [256];
    logic [7:0]  m_ct   [256];
    logic [7:0]  m_s    [256];
    logic [7:0]  orig   [256];
    int          wcount = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    arc4_encrypt dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .en_i        (en),
        .rdy_o       (rdy),
        .key_i       (key),
        .pt_addr_o   (pt_addr),
        .pt_rddata_i (pt_rddata),
        .ct_addr_o   (ct_addr),
        .ct_wrdata_o (ct_wrdata),
        .ct_wren_o   (ct_wren),
        .s_addr_o    (s_addr),
        .s_wrdata_o  (s_wrdata),
        .s_wren_o    (s_wren),
        .s_rddata_i  (s_rddata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        pt_rddata <= pt_mem[pt_addr];
        s_rddata  <= s_mem[s_addr];
        if (s_wren) s_mem[s_addr] <= s_wrdata;
        if (ct_wren) begin
            ct_mem[ct_addr] <= ct_wrdata;
            wcount <= wcount + 1;
        end
    end

    // Textbook ARC4: identity S, key schedule, then len keystream bytes XORed onto pt_mem[1..len]
    task automatic model(input logic [23:0] k, input int len);
        int s [256];
        int i, j, t;
        for (int n = 0; n < 256; n++) s[n] = n;
        j = 0;
        for (int n = 0; n < 256; n++) begin
            j = (j + s[n] + int'((k >> (8 * (2 - n % 3))) & 24'hFF)) % 256;
            t = s[n]; s[n] = s[j]; s[j] = t;
        end
        for (int n = 0; n < 256; n++) m_s[n] = 8'(s[n]);
        i = 0;
        j = 0;
        m_ct[0] = 8'(len);
        for (int n = 1; n <= len; n++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            m_ct[n] = pt_mem[n] ^ 8'(s[(s[i] + s[j]) % 256]);
        end
    endtask

    task automatic wait_rdy(output int cyc);
        cyc = 0;
        @(negedge clk);
        while (!rdy && cyc < 5000) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic check_run(input logic [23:0] k, input int len, input int cyc, input int w0, input string tag);
        int mism, first;
        n_chk++;
        if (cyc !== 1282 + 6 * len) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d", tag, cyc, 1282 + 6 * len);
        end
        n_chk++;
        if (wcount - w0 !== len + 1) begin
            n_fail++;
            $display("FAIL %s ct write count: got %0d expected %0d", tag, wcount - w0, len + 1);
        end
        model(k, len);
        mism = 0;
        first = -1;
        for (int n = 0; n <= len; n++) if (ct_mem[n] !== m_ct[n]) begin
            mism++;
            if (first < 0) first = n;
        end
        n_chk++;
        if (mism != 0) begin
            n_fail++;
            $display("FAIL %s ct bytes: %0d wrong, first ct[%0d] got %h expected %h",
                     tag, mism, first, ct_mem[first], m_ct[first]);
        end
    endtask

    task automatic run_op(input logic [23:0] k, input int len, input string tag);
        int cyc, w0;
        @(negedge clk);
        en = 1'b1;
        key = k;
        w0 = wcount;
        @(posedge clk);
        #1 en = 1'b0;
        wait_rdy(cyc);
        check_run(k, len, cyc, w0, tag);
    endtask

    task automatic test_reset;
        int wr;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (rdy !== 1'b1 || ct_wren !== 1'b0 || s_wren !== 1'b0) begin
            n_fail++;
            $display("FAIL reset flags: rdy=%b ct_wren=%b s_wren=%b expected 1 0 0", rdy, ct_wren, s_wren);
        end
        n_chk++;
        if ({pt_addr, ct_addr, ct_wrdata, s_addr, s_wrdata} !== 40'd0) begin
            n_fail++;
            $display("FAIL reset outputs: got %h expected 0", {pt_addr, ct_addr, ct_wrdata, s_addr, s_wrdata});
        end
        @(negedge clk);
        rst_n = 1'b1;
        wr = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ct_wren || s_wren || !rdy) wr++;
        end
        n_chk++;
        if (wr != 0) begin
            n_fail++;
            $display("FAIL idle quiet: %0d active cycles expected 0", wr);
        end
    endtask

    task automatic test_zero_len;
        int mism;
        pt_mem[0] = 8'd0;
        run_op(24'h000018, 0, "zero_len");
        mism = 0;
        for (int n = 0; n < 256; n++) if (s_mem[n] !== m_s[n]) mism++;
        n_chk++;
        if (mism != 0) begin
            n_fail++;
            $display("FAIL zero_len sbox: %0d entries differ, S[0] got %h expected %h", mism, s_mem[0], m_s[0]);
        end
        n_chk++;
        if (rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_len rdy: got %b expected 1", rdy);
        end
    endtask

    task automatic test_known;
        logic [39:0] hello;
        hello = "hello";
        pt_mem[0] = 8'd5;
        for (int n = 1; n <= 5; n++) pt_mem[n] = hello[8 * (5 - n) +: 8];
        run_op(24'h1E4600, 5, "known");
        n_chk++;
        if (ct_mem[0] !== 8'd5) begin
            n_fail++;
            $display("FAIL known length byte: got %0d expected 5", ct_mem[0]);
        end
    endtask

    task automatic test_round_trip;
        int mism;
        pt_mem[0] = 8'd255;
        for (int n = 1; n < 256; n++) begin
            orig[n] = 8'($urandom);
            pt_mem[n] = orig[n];
        end
        run_op(24'hFFFFFF, 255, "rt_enc");
        for (int n = 0; n < 256; n++) pt_mem[n] = ct_mem[n];
        run_op(24'hFFFFFF, 255, "rt_dec");
        mism = 0;
        for (int n = 1; n < 256; n++) if (ct_mem[n] !== orig[n]) mism++;
        n_chk++;
        if (mism != 0) begin
            n_fail++;
            $display("FAIL round trip: %0d bytes differ from original, expected 0", mism);
        end
    endtask

    task automatic test_back_to_back;
        logic [23:0] ka, kb;
        int cyc, w0, busy;
        ka = 24'($urandom);
        kb = ka ^ 24'h5A5A5A;
        pt_mem[0] = 8'd7;
        for (int n = 1; n <= 7; n++) pt_mem[n] = 8'($urandom);
        @(negedge clk);
        en = 1'b1;
        key = ka;
        w0 = wcount;
        @(posedge clk);
        #1 key = kb;
        n_chk++;
        if (rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy rdy after accept: got %b expected 0", rdy);
        end
        wait_rdy(cyc);
        check_run(ka, 7, cyc, w0, "busy_latched_key");
        w0 = wcount;
        @(posedge clk);
        #1;
        en = 1'b0;
        key = 24'($urandom);
        n_chk++;
        if (rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL back-to-back accept: rdy got %b expected 0", rdy);
        end
        wait_rdy(cyc);
        check_run(kb, 7, cyc, w0, "back_to_back");
        w0 = wcount;
        busy = 0;
        repeat (10) begin
            @(negedge clk);
            if (!rdy) busy++;
        end
        n_chk++;
        if (busy != 0 || wcount != w0) begin
            n_fail++;
            $display("FAIL single op per start: busy=%0d writes=%0d expected 0 0", busy, wcount - w0);
        end
    endtask

    task automatic test_reset_mid;
        int cyc, w0;
        pt_mem[0] = 8'd8;
        for (int n = 1; n <= 8; n++) pt_mem[n] = 8'($urandom);
        @(negedge clk);
        en = 1'b1;
        key = 24'($urandom);
        @(posedge clk);
        #1 en = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (!(ct_wren && ct_addr == 8'd3) && cyc < 5000) begin
            cyc++;
            @(negedge clk);
        end
        n_chk++;
        if (cyc >= 5000) begin
            n_fail++;
            $display("FAIL reset_mid reaching k=3: got timeout expected ct write at 3");
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1 w0 = wcount;
        n_chk++;
        if (rdy !== 1'b1 || ct_wren !== 1'b0 || s_wren !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid flags: rdy=%b ct_wren=%b s_wren=%b expected 1 0 0", rdy, ct_wren, s_wren);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        n_chk++;
        if (wcount != w0 || rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid quiet: writes=%0d rdy=%b expected 0 1", wcount - w0, rdy);
        end
        pt_mem[0] = 8'd5;
        for (int n = 1; n <= 5; n++) pt_mem[n] = 8'($urandom);
        run_op(24'($urandom), 5, "after_reset");
    endtask

    initial begin
        test_reset;
        test_zero_len;
        test_known;
        test_round_trip;
        test_back_to_back;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
